// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: Q3.6 fixed-point types, constants and saturation shared by the training datapath.
package nn_fixed_pkg;
  localparam int W = 10;
  localparam int FRAC = 6;
  localparam int ONE = 64;
  localparam int MAXV = 511;
  localparam int MINV = -512;
  typedef logic signed [W-1:0] fx_t;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} upd_state_t;
  function automatic fx_t sat_fx(input logic signed [2*W:0] v);
    return (v > (2*W+1)'(MAXV)) ? fx_t'(MAXV) : (v < (2*W+1)'(MINV)) ? fx_t'(MINV) : v[W-1:0];
  endfunction
endpackage

// File: rtl/weight_grad_step.sv
// weight_grad_step: one combinational gradient step, w - floor(delta*x / 2^(FRAC+LR_SHIFT)), saturated.
module weight_grad_step
  import nn_fixed_pkg::*;
#(
  parameter int LR_SHIFT = 3
) (
  input  fx_t w,
  input  fx_t delta,
  input  fx_t x,
  output fx_t w_new
);
  logic signed [2*W-1:0] p, g;
  logic signed [2*W:0] d;
  assign p = (2*W)'(delta) * (2*W)'(x);
  assign g = p >>> (FRAC + LR_SHIFT);
  assign d = (2*W+1)'(w) - (2*W+1)'(g);
  assign w_new = sat_fx(d);
endmodule

// File: rtl/hidden_weight_update.sv
// hidden_weight_update: input-to-hidden weight file with a sequential one-weight-per-cycle gradient pass.
module hidden_weight_update
  import nn_fixed_pkg::*;
#(
  parameter int N_HID = 5,
  parameter int N_IN = 4,
  parameter int LR_SHIFT = 3,
  localparam int HW = $clog2(N_HID),
  localparam int IW = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  fx_t           delta0 [N_HID],
  input  fx_t           x_in [N_IN],
  input  logic          wr_en,
  input  logic [HW-1:0] wr_hid,
  input  logic [IW-1:0] wr_idx,
  input  fx_t           wr_data,
  input  logic [HW-1:0] rd_hid,
  input  logic [IW-1:0] rd_idx,
  output fx_t           rd_data,
  output logic          busy,
  output logic          done
);
  localparam logic [HW-1:0] HMAX = HW'(N_HID - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_IN - 1);
  upd_state_t state;
  fx_t wt [N_HID][N_IN];
  fx_t dl [N_HID];
  fx_t xl [N_IN];
  logic [HW-1:0] h;
  logic [IW-1:0] i;
  fx_t w_new;
  logic wr_ok;
  assign wr_ok = wr_en && wr_hid <= HMAX && wr_idx <= IMAX;
  assign rd_data = (rd_hid <= HMAX && rd_idx <= IMAX) ? wt[rd_hid][rd_idx] : '0;
  weight_grad_step #(.LR_SHIFT(LR_SHIFT)) u_step (
    .w(wt[h][i]),
    .delta(dl[h]),
    .x(xl[i]),
    .w_new(w_new)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h <= '0;
      i <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dl <= '{default: '0};
      xl <= '{default: '0};
      wt <= '{default: '{default: '0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok) wt[wr_hid][wr_idx] <= wr_data;
          if (start) begin
            dl <= delta0;
            xl <= x_in;
            h <= '0;
            i <= '0;
            busy <= 1'b1;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          wt[h][i] <= w_new;
          if (i == IMAX) begin
            i <= '0;
            if (h == HMAX) begin
              h <= '0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end else h <= h + 1'b1;
          end else i <= i + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hidden_weight_update.sv
// tb_hidden_weight_update: directed passes; expected reads and done timing queued, checked by a negedge monitor.
module tb_hidden_weight_update;
  import nn_fixed_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, wr_en = 0;
  logic [2:0] wr_hid = 0, rd_hid = 0;
  logic [1:0] wr_idx = 0, rd_idx = 0;
  fx_t wr_data = '0;
  fx_t rd_data;
  fx_t delta0 [5];
  fx_t x_in [4];
  logic busy, done;
  int cyc = 0, n_chk = 0, n_fail = 0, busy_cnt = 0;
  bit rd_req = 0, fin = 0;
  typedef struct {int h; int i; int val;} exp_t;
  exp_t rd_q[$];
  int done_q[$];
  exp_t e;
  int dc;

  hidden_weight_update dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delta0(delta0), .x_in(x_in),
    .wr_en(wr_en), .wr_hid(wr_hid), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_hid(rd_hid), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
    end else if (busy) busy_cnt++;
    if (rd_req) begin
      if (rd_q.size() == 0) check("rd_queue_underflow", 1, 0);
      else begin
        e = rd_q.pop_front();
        check($sformatf("rd[%0d][%0d]", e.h, e.i), int'(rd_data), e.val);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        dc = done_q.pop_front();
        check("done_cycle", cyc, dc);
        check("busy_cycles", busy_cnt, 20);
        check("busy_low_at_done", int'(busy), 0);
      end
      busy_cnt = 0;
    end
    if (fin) begin
      check("rd_queue_empty", rd_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int h, input int i, input int d);
    wr_en = 1; wr_hid = 3'(h); wr_idx = 2'(i); wr_data = fx_t'(d);
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input int h, input int i, input int v);
    exp_t x;
    x.h = h; x.i = i; x.val = v;
    rd_hid = 3'(h); rd_idx = 2'(i);
    rd_q.push_back(x);
    rd_req = 1;
    tick();
    rd_req = 0;
  endtask

  task automatic go();
    start = 1;
    done_q.push_back(cyc + 21);
    tick();
    start = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) tick();
    if (!done) $display("FAIL done_timeout: got no done expected done pulse");
    tick();
  endtask

  task automatic set_dx(input int d0, d1, d2, d3, d4, x0, x1, x2, x3);
    delta0[0] = fx_t'(d0); delta0[1] = fx_t'(d1); delta0[2] = fx_t'(d2);
    delta0[3] = fx_t'(d3); delta0[4] = fx_t'(d4);
    x_in[0] = fx_t'(x0); x_in[1] = fx_t'(x1); x_in[2] = fx_t'(x2); x_in[3] = fx_t'(x3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    set_dx(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rd(0, 0, 0);
    rd(4, 3, 0);
    rst_n = 1;
    tick();
    // all-ones pass: every weight steps by -(4096 >>> 9) = -8
    set_dx(64, 64, 64, 64, 64, 64, 64, 64, 64);
    go();
    wait_done();
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 4; b++) rd(a, b, -8);
    // negative gradient, plus a load in the same cycle as start
    wr(0, 0, 0);
    set_dx(-64, 0, 0, 0, 64, 64, 0, 0, 64);
    wr_en = 1; wr_hid = 3'd4; wr_idx = 2'd3; wr_data = fx_t'(100);
    go();
    wr_en = 0;
    wait_done();
    rd(0, 0, 8);
    rd(0, 3, 0);
    rd(4, 3, 92);
    rd(4, 0, -16);
    // floor rounding of a tiny negative product
    wr(1, 0, 0);
    set_dx(0, -1, 0, 0, 0, 1, 0, 0, 0);
    go();
    wait_done();
    rd(1, 0, 1);
    rd(1, 1, -8);
    // saturation, with stray starts, a blocked load and a mid-pass delta change
    wr(2, 3, -510);
    wr(3, 0, 508);
    set_dx(0, 0, 511, -512, 0, 511, 0, 0, 511);
    c0 = cyc;
    go();
    set_dx(100, 100, 100, 100, 100, 511, 0, 0, 511);
    repeat (3) tick();
    start = 1;
    tick();
    start = 0;
    wr(4, 0, 200);
    while (cyc < c0 + 20) tick();
    start = 1;
    tick();
    tick();
    start = 0;
    tick();
    rd(2, 3, -512);
    rd(3, 0, 511);
    rd(2, 0, -512);
    rd(3, 3, 503);
    rd(4, 0, -16);
    // reset mid-pass aborts and clears everything
    set_dx(64, 64, 64, 64, 64, 64, 64, 64, 64);
    go();
    repeat (8) tick();
    rst_n = 0;
    void'(done_q.pop_back());
    rd(2, 3, 0);
    rd(3, 0, 0);
    rd(0, 0, 0);
    rst_n = 1;
    tick();
    go();
    wait_done();
    rd(2, 2, -8);
    rd(4, 3, -8);
    // zero delta leaves weights alone; out-of-range reads give 0
    wr(0, 1, 100);
    wr(3, 2, -200);
    wr(5, 0, 77);
    set_dx(0, 0, 0, 0, 0, 64, 64, 64, 64);
    go();
    wait_done();
    rd(0, 1, 100);
    rd(3, 2, -200);
    rd(1, 1, -8);
    rd(5, 0, 0);
    rd(7, 3, 0);
    tick();
    fin = 1;
    repeat (5) tick();
  end
endmodule
